// File: rtl/lcd_defs.sv
// Shared definitions for the LCD draw arbiter: FSM states, requester indices
// and small helpers for round-robin pointer arithmetic.
`timescale 1ns/1ps
package lcd_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_DRAIN   = 2'd2
    } arb_state_t;

    localparam logic [1:0] REQ_PIC  = 2'd0;
    localparam logic [1:0] REQ_FILL = 2'd1;
    localparam logic [1:0] REQ_CHAR = 2'd2;

    // Wraps 2 back to 0; an illegal pointer value of 3 also restarts at 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= REQ_CHAR) ? REQ_PIC : idx + 2'd1;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        case (oh)
            3'b010:  return REQ_FILL;
            3'b100:  return REQ_CHAR;
            default: return REQ_PIC;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational 3-way round-robin picker: scans upward from the requester
// after 'last' and returns the first active request as a one-hot vector.
`timescale 1ns/1ps
module lcd_rr_pick
    import lcd_defs::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] pick
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = rr_next(last);
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                pick[cand] = 1'b1;
                found      = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/lcd_draw_arbiter.sv
// Arbitrates three drawing engines onto a single LCD byte-write engine with
// round-robin grants, one write in flight at a time, and a silence watchdog.
`timescale 1ns/1ps
module lcd_draw_arbiter
    import lcd_defs::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd65535,
    parameter logic [1:0]  RR_INIT     = 2'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] rel,
    input  logic [2:0] wr_en,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic       dc0,
    input  logic       dc1,
    input  logic       dc2,
    output logic [2:0] gnt,
    output logic [2:0] wr_done_o,
    output logic       lcd_wr_en,
    output logic [7:0] lcd_data,
    output logic       lcd_dc,
    input  logic       lcd_wr_done,
    output logic       busy,
    output logic       timeout_err
);

    arb_state_t  state;
    logic        outstanding;
    logic [15:0] idle_cnt;
    logic [1:0]  last;
    logic [2:0]  pick;

    logic holder_wr;
    logic holder_rel;
    logic done_ok;
    logic timeout_hit;
    logic fwd;
    logic out_next;

    lcd_rr_pick u_pick (
        .req  (req),
        .last (last),
        .pick (pick)
    );

    // A write is forwarded only while granted and the engine is free, or is
    // finishing its previous byte in this very cycle; the watchdog overrides.
    always_comb begin
        holder_wr   = |(wr_en & gnt);
        holder_rel  = |(rel & gnt);
        done_ok     = lcd_wr_done & outstanding;
        timeout_hit = (state != ST_IDLE) && (idle_cnt >= TIMEOUT_CYC);
        fwd         = (state == ST_GRANTED) && holder_wr
                      && (!outstanding || done_ok) && !timeout_hit;
        out_next    = fwd | (outstanding & ~done_ok);
    end

    assign lcd_wr_en = fwd;
    assign lcd_data  = ({8{gnt[REQ_PIC]}}  & data0)
                     | ({8{gnt[REQ_FILL]}} & data1)
                     | ({8{gnt[REQ_CHAR]}} & data2);
    assign lcd_dc    = |(gnt & {dc2, dc1, dc0});
    assign wr_done_o = gnt & {3{done_ok}};
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            outstanding <= 1'b0;
            idle_cnt    <= '0;
            last        <= RR_INIT;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (timeout_hit) begin
                state       <= ST_IDLE;
                gnt         <= '0;
                outstanding <= 1'b0;
                idle_cnt    <= '0;
                timeout_err <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        outstanding <= 1'b0;
                        if (|req) begin
                            state    <= ST_GRANTED;
                            gnt      <= pick;
                            last     <= onehot_to_idx(pick);
                            idle_cnt <= '0;
                        end
                    end
                    ST_GRANTED: begin
                        outstanding <= out_next;
                        idle_cnt    <= (fwd || done_ok) ? 16'd0 : sat_inc(idle_cnt);
                        // Releasing with a byte still in flight waits in DRAIN.
                        if (holder_rel) begin
                            if (out_next) begin
                                state <= ST_DRAIN;
                            end else begin
                                state    <= ST_IDLE;
                                gnt      <= '0;
                                idle_cnt <= '0;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (done_ok) begin
                            state       <= ST_IDLE;
                            gnt         <= '0;
                            outstanding <= 1'b0;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= sat_inc(idle_cnt);
                        end
                    end
                    default: begin
                        state       <= ST_IDLE;
                        gnt         <= '0;
                        outstanding <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_draw_arbiter.sv
// Self-checking bench for lcd_draw_arbiter: directed vector table, multi-cycle
// drain/reset/timeout sequences, and random traffic against a reference model.
`timescale 1ns/1ps
module tb_lcd_draw_arbiter;

    localparam int TO_CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] req = '0;
    logic [2:0] rel = '0;
    logic [2:0] wr_en = '0;
    logic [7:0] data0 = '0;
    logic [7:0] data1 = '0;
    logic [7:0] data2 = '0;
    logic       dc0 = 1'b0;
    logic       dc1 = 1'b0;
    logic       dc2 = 1'b0;
    logic       lcd_wr_done = 1'b0;

    logic [2:0] gnt, wr_done_o;
    logic       lcd_wr_en, lcd_dc, busy, timeout_err;
    logic [7:0] lcd_data;
    logic [2:0] t_gnt, t_wr_done_o;
    logic       t_lcd_wr_en, t_lcd_dc, t_busy, t_timeout_err;
    logic [7:0] t_lcd_data;

    lcd_draw_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .wr_en(wr_en),
        .data0(data0), .data1(data1), .data2(data2),
        .dc0(dc0), .dc1(dc1), .dc2(dc2),
        .gnt(gnt), .wr_done_o(wr_done_o), .lcd_wr_en(lcd_wr_en),
        .lcd_data(lcd_data), .lcd_dc(lcd_dc), .lcd_wr_done(lcd_wr_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    lcd_draw_arbiter #(.TIMEOUT_CYC(16'd16)) dut_to (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .wr_en(wr_en),
        .data0(data0), .data1(data1), .data2(data2),
        .dc0(dc0), .dc1(dc1), .dc2(dc2),
        .gnt(t_gnt), .wr_done_o(t_wr_done_o), .lcd_wr_en(t_lcd_wr_en),
        .lcd_data(t_lcd_data), .lcd_dc(t_lcd_dc), .lcd_wr_done(lcd_wr_done),
        .busy(t_busy), .timeout_err(t_timeout_err)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model of the 16-cycle-timeout instance: who holds the grant,
    // whether a byte is pending, and how many silent cycles have elapsed.
    int m_holder, m_silent, m_last;
    bit m_drain, m_pend, m_terr;

    task automatic model_reset();
        m_holder = -1; m_silent = 0; m_last = 2;
        m_drain = 0; m_pend = 0; m_terr = 0;
    endtask

    function automatic logic [2:0] m_gnt();
        return (m_holder < 0) ? 3'b000 : 3'(1 << m_holder);
    endfunction

    function automatic logic [7:0] m_data();
        case (m_holder)
            0: return data0;
            1: return data1;
            2: return data2;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic m_dc();
        case (m_holder)
            0: return dc0;
            1: return dc1;
            2: return dc2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_done_ok();
        return lcd_wr_done && m_pend;
    endfunction

    function automatic bit m_timeout();
        return (m_holder >= 0) && (m_silent >= TO_CYC);
    endfunction

    function automatic bit m_fwd();
        if (m_holder < 0 || m_drain || m_timeout()) return 0;
        return wr_en[m_holder] && (!m_pend || m_done_ok());
    endfunction

    task automatic model_step();
        bit dok, fw, np, got;
        dok = m_done_ok();
        fw  = m_fwd();
        if (m_holder < 0) begin
            m_terr = 0;
            got = 0;
            for (int k = 1; k <= 3; k++) begin
                if (!got && req[(m_last + k) % 3]) begin
                    m_holder = (m_last + k) % 3;
                    got = 1;
                end
            end
            if (got) begin
                m_last = m_holder; m_silent = 0; m_pend = 0; m_drain = 0;
            end
        end else if (m_timeout()) begin
            m_holder = -1; m_pend = 0; m_drain = 0; m_silent = 0; m_terr = 1;
        end else begin
            m_terr = 0;
            np = fw || (m_pend && !dok);
            m_silent = (fw || dok) ? 0 : ((m_silent < 65535) ? m_silent + 1 : m_silent);
            if (!m_drain) begin
                if (rel[m_holder]) begin
                    if (np) m_drain = 1;
                    else m_holder = -1;
                end
            end else if (dok) begin
                m_holder = -1;
            end
            m_pend = np;
            if (m_holder < 0) begin
                m_pend = 0; m_drain = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] rl, input logic [2:0] we,
                                 input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                 input logic [2:0] dcs, input logic done);
        @(negedge clk);
        req = r; rel = rl; wr_en = we;
        data0 = d0; data1 = d1; data2 = d2;
        {dc2, dc1, dc0} = dcs;
        lcd_wr_done = done;
        #2;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; rel = '0; wr_en = '0; lcd_wr_done = 1'b0;
        data0 = '0; data1 = '0; data2 = '0; {dc2, dc1, dc0} = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_model(input string tag);
        checkOutput({tag, "_gnt"},  16'(t_gnt),         16'(m_gnt()));
        checkOutput({tag, "_wr"},   16'(t_lcd_wr_en),   16'(m_fwd()));
        checkOutput({tag, "_data"}, 16'(t_lcd_data),    16'(m_data()));
        checkOutput({tag, "_dc"},   16'(t_lcd_dc),      16'(m_dc()));
        checkOutput({tag, "_done"}, 16'(t_wr_done_o),   16'(m_done_ok() ? m_gnt() : 3'b000));
        checkOutput({tag, "_busy"}, 16'(t_busy),        16'(m_holder >= 0));
        checkOutput({tag, "_terr"}, 16'(t_timeout_err), 16'(m_terr));
    endtask

    typedef struct {
        logic [2:0] req;
        logic [2:0] rel;
        logic [2:0] wr_en;
        logic [7:0] d1;
        logic       dc1;
        logic       done;
        logic [2:0] e_gnt;
        logic       e_wr;
        logic [7:0] e_data;
        logic       e_dc;
        logic [2:0] e_done;
        logic       e_busy;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] r, rl, we;
        logic       done, quiet, seen;
        int         n;

        // req/rel/wr_en/d1/dc1/done -> gnt/wr/data/dc/done_o/busy (data0=11 dc0=1, data2=33 dc2=1)
        vecs[0]  = '{3'b111, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0};
        vecs[1]  = '{3'b111, 3'b001, 3'b000, 8'h00, 1'b0, 1'b0, 3'b001, 1'b0, 8'h11, 1'b1, 3'b000, 1'b1};
        vecs[2]  = '{3'b111, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0};
        vecs[3]  = '{3'b111, 3'b000, 3'b010, 8'h2C, 1'b0, 1'b0, 3'b010, 1'b1, 8'h2C, 1'b0, 3'b000, 1'b1};
        vecs[4]  = '{3'b111, 3'b000, 3'b001, 8'h2C, 1'b0, 1'b0, 3'b010, 1'b0, 8'h2C, 1'b0, 3'b000, 1'b1};
        vecs[5]  = '{3'b111, 3'b000, 3'b010, 8'h55, 1'b1, 1'b0, 3'b010, 1'b0, 8'h55, 1'b1, 3'b000, 1'b1};
        vecs[6]  = '{3'b111, 3'b000, 3'b000, 8'h55, 1'b1, 1'b1, 3'b010, 1'b0, 8'h55, 1'b1, 3'b010, 1'b1};
        vecs[7]  = '{3'b111, 3'b000, 3'b000, 8'h55, 1'b1, 1'b1, 3'b010, 1'b0, 8'h55, 1'b1, 3'b000, 1'b1};
        vecs[8]  = '{3'b111, 3'b100, 3'b000, 8'h55, 1'b1, 1'b0, 3'b010, 1'b0, 8'h55, 1'b1, 3'b000, 1'b1};
        vecs[9]  = '{3'b111, 3'b010, 3'b000, 8'h55, 1'b1, 1'b0, 3'b010, 1'b0, 8'h55, 1'b1, 3'b000, 1'b1};
        vecs[10] = '{3'b111, 3'b000, 3'b000, 8'h55, 1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0};
        vecs[11] = '{3'b111, 3'b100, 3'b000, 8'h55, 1'b1, 1'b0, 3'b100, 1'b0, 8'h33, 1'b1, 3'b000, 1'b1};
        vecs[12] = '{3'b111, 3'b000, 3'b000, 8'h55, 1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0};
        vecs[13] = '{3'b000, 3'b000, 3'b000, 8'h55, 1'b1, 1'b0, 3'b001, 1'b0, 8'h11, 1'b1, 3'b000, 1'b1};
        vecs[14] = '{3'b000, 3'b001, 3'b000, 8'h55, 1'b1, 1'b0, 3'b001, 1'b0, 8'h11, 1'b1, 3'b000, 1'b1};
        vecs[15] = '{3'b000, 3'b000, 3'b000, 8'h55, 1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0};

        #1 rst_n = 1'b0;
        #4;
        checkOutput("reset_gnt",  16'(gnt),         16'h0);
        checkOutput("reset_busy", 16'(busy),        16'h0);
        checkOutput("reset_terr", 16'(timeout_err), 16'h0);
        checkOutput("reset_wr",   16'(lcd_wr_en),   16'h0);

        $display("[TB] directed vector table");
        do_reset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].req, vecs[i].rel, vecs[i].wr_en, 8'h11, vecs[i].d1, 8'h33,
                          {1'b1, vecs[i].dc1, 1'b1}, vecs[i].done);
            checkOutput($sformatf("v%0d_gnt", i),  16'(gnt),         16'(vecs[i].e_gnt));
            checkOutput($sformatf("v%0d_wr", i),   16'(lcd_wr_en),   16'(vecs[i].e_wr));
            checkOutput($sformatf("v%0d_data", i), 16'(lcd_data),    16'(vecs[i].e_data));
            checkOutput($sformatf("v%0d_dc", i),   16'(lcd_dc),      16'(vecs[i].e_dc));
            checkOutput($sformatf("v%0d_done", i), 16'(wr_done_o),   16'(vecs[i].e_done));
            checkOutput($sformatf("v%0d_busy", i), 16'(busy),        16'(vecs[i].e_busy));
            checkOutput($sformatf("v%0d_terr", i), 16'(timeout_err), 16'h0);
            advance();
        end

        $display("[TB] release while a write is outstanding");
        do_reset();
        applyStimulus(3'b001, 3'b000, 3'b000, 8'h3A, 8'h00, 8'h00, 3'b000, 1'b0);
        advance();
        applyStimulus(3'b001, 3'b000, 3'b001, 8'h3A, 8'h00, 8'h00, 3'b000, 1'b0);
        checkOutput("drain_fwd", 16'(lcd_wr_en), 16'h1);
        advance();
        applyStimulus(3'b000, 3'b001, 3'b000, 8'h3A, 8'h00, 8'h00, 3'b000, 1'b0);
        checkOutput("drain_rel_gnt", 16'(gnt), 16'h1);
        advance();
        for (int k = 0; k < 49; k++) begin
            applyStimulus(3'b000, 3'b000, 3'b000, 8'h3A, 8'h00, 8'h00, 3'b000, 1'b0);
            checkOutput("drain_busy", 16'(busy), 16'h1);
            checkOutput("drain_gnt",  16'(gnt),  16'h1);
            advance();
        end
        applyStimulus(3'b000, 3'b000, 3'b000, 8'h3A, 8'h00, 8'h00, 3'b000, 1'b1);
        checkOutput("drain_done_o", 16'(wr_done_o), 16'h1);
        checkOutput("drain_done_busy", 16'(busy), 16'h1);
        advance();
        applyStimulus(3'b000, 3'b000, 3'b000, 8'h3A, 8'h00, 8'h00, 3'b000, 1'b0);
        checkOutput("drain_end_gnt",  16'(gnt),  16'h0);
        checkOutput("drain_end_busy", 16'(busy), 16'h0);

        $display("[TB] reset during a write");
        do_reset();
        applyStimulus(3'b001, 3'b000, 3'b000, 8'hA5, 8'h00, 8'h00, 3'b001, 1'b0);
        advance();
        applyStimulus(3'b001, 3'b000, 3'b001, 8'hA5, 8'h00, 8'h00, 3'b001, 1'b0);
        checkOutput("rst_pre_wr", 16'(lcd_wr_en), 16'h1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_gnt",  16'(gnt),       16'h0);
        checkOutput("rst_async_wr",   16'(lcd_wr_en), 16'h0);
        checkOutput("rst_async_data", 16'(lcd_data),  16'h0);
        checkOutput("rst_async_dc",   16'(lcd_dc),    16'h0);
        checkOutput("rst_async_busy", 16'(busy),      16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        applyStimulus(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
        checkOutput("rst_late_done",   16'(wr_done_o),   16'h0);
        checkOutput("rst_late_done_t", 16'(t_wr_done_o), 16'h0);

        $display("[TB] silent holder watchdog");
        do_reset();
        applyStimulus(3'b011, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
        advance();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            advance();
            n++;
            applyStimulus(3'b011, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
            if (n == 16) checkOutput("to_still_held", 16'(t_gnt), 16'h1);
            if (t_timeout_err) seen = 1'b1;
        end
        checkOutput("to_cycles", 16'(n), 16'd17);
        checkOutput("to_gnt_dropped", 16'(t_gnt), 16'h0);
        advance();
        applyStimulus(3'b011, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
        checkOutput("to_pulse_end", 16'(t_timeout_err), 16'h0);
        checkOutput("to_next_gnt",  16'(t_gnt),         16'h2);

        $display("[TB] randomized traffic against reference model");
        do_reset();
        for (int c = 0; c < 600; c++) begin
            quiet = (((c / 48) % 4) == 3);
            r  = 3'($urandom_range(0, 7));
            rl = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            we = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            done = ($urandom_range(0, 9) < 3);
            if (quiet) begin
                rl = '0; we = '0; done = 1'b0;
            end
            applyStimulus(r, rl, we, 8'($urandom), 8'($urandom), 8'($urandom),
                          3'($urandom_range(0, 7)), done);
            check_model("rnd");
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_draw_arbiter.md
LCD_DRAW_ARBITER -- requirements
Module: lcd_draw_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd65535: idle cycles a grant holder may stay silent before forced release.
REQ-002 SHALL have parameter RR_INIT, default 2'd2: reset value of last-granted pointer, so requester 0 wins first.
REQ-003 clk  in  1  single system clock (50 MHz); all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  3  per-requester level request (bit i = drawing engine i: ShowPicture, Fill, ShowChar).
REQ-006 rel  in  3  per-requester single-cycle release pulse.
REQ-007 wr_en  in  3  per-requester byte-write strobe.
REQ-008 data0, data1, data2  in  8 each  per-requester write byte.
REQ-009 dc0, dc1, dc2  in  1 each  per-requester command(0)/data(1) flag.
REQ-010 gnt  out  3  one-hot grant, or all zero.
REQ-011 wr_done_o  out  3  lcd_wr_done routed to the grant holder only.
REQ-012 lcd_wr_en, lcd_data[7:0], lcd_dc  out  1/8/1  to the single LCD byte-write engine.
REQ-013 lcd_wr_done  in  1  single-cycle completion pulse from the write engine.
REQ-014 busy  out  1  high in GRANTED or DRAIN.
REQ-015 timeout_err  out  1  one-cycle pulse on forced release.

Function
REQ-016 FSM states SHALL be IDLE, GRANTED, DRAIN.
REQ-017 IDLE with any req bit high: next edge enters GRANTED, gnt one-hot, 1-cycle grant latency.
REQ-018 Selection SHALL be round-robin: scan from (last+1) mod 3 upward; the winner becomes last.
REQ-019 gnt SHALL stay stable throughout GRANTED and DRAIN regardless of req changes.
REQ-020 lcd_wr_en, lcd_data, lcd_dc SHALL be a combinational mux of the grant holder's signals.
REQ-021 lcd_wr_en SHALL be 0 when no grant is held; lcd_data and lcd_dc SHALL then be 0.
REQ-022 wr_en from non-granted requesters SHALL be ignored.
REQ-023 An outstanding flag SHALL set on a forwarded lcd_wr_en and clear on lcd_wr_done.
REQ-024 While outstanding=1 and no lcd_wr_done arrives that cycle, the holder's wr_en SHALL NOT be forwarded.
REQ-025 lcd_wr_done and a new wr_en in the same cycle SHALL forward the write; outstanding stays 1.
REQ-026 wr_done_o[i] = lcd_wr_done AND gnt[i], combinational.
REQ-027 lcd_wr_done with outstanding=0 SHALL be ignored and not routed.
REQ-028 rel[gnt idx] with outstanding=0 (or done the same cycle): next edge to IDLE, gnt=0.
REQ-029 rel with outstanding=1: go to DRAIN; on lcd_wr_done, to IDLE.
REQ-030 rel bits of non-holders SHALL be ignored.
REQ-031 Timeout counter, 16 bits: clears on grant, forwarded write, or lcd_wr_done; increments otherwise in GRANTED/DRAIN, saturating.
REQ-032 Counter reaching TIMEOUT_CYC SHALL act as release from any state, clear outstanding, and pulse timeout_err.
REQ-033 IDLE SHALL last at least 1 cycle between grants; no back-to-back handover.

Reset
REQ-034 Asynchronous assertion SHALL give: state=IDLE, gnt=0, outstanding=0, counter=0, last=RR_INIT, timeout_err=0, busy=0.
REQ-035 Reset mid-transfer SHALL drop the grant immediately; a write in flight is abandoned with no wr_done_o.
REQ-036 Deassertion SHALL take effect synchronously at the next clk edge.

Structure
REQ-037 FSM state encodings and requester index constants (REQ_PIC=0, REQ_FILL=1, REQ_CHAR=2) SHALL live in the shared lcd_defs package/header.
REQ-038 One sub-module SHALL be used: lcd_rr_pick, a combinational 3-way round-robin picker taking req and last, giving a one-hot result.

Verification
REQ-039 req=3'b111 after reset -> gnt 001; release -> 010; release -> 100; release -> 001.
REQ-040 Holder 1 writes data1=8'h2C, dc1=0 -> lcd_data=8'h2C, lcd_dc=0, lcd_wr_en=1 the same cycle; lcd_wr_done -> wr_done_o=3'b010.
REQ-041 wr_en0 pulsed while gnt=010 -> lcd_wr_en stays 0; second wr_en1 before done -> not forwarded.
REQ-042 rel while outstanding -> busy=1 in DRAIN until lcd_wr_done at +1000 ns; then gnt=0 next edge.
REQ-043 TIMEOUT_CYC=16, holder silent -> timeout_err pulse after 16 cycles, gnt=0, next requester granted after 1 IDLE cycle.
REQ-044 rst_n low mid-write -> all outputs 0 asynchronously; later lcd_wr_done produces no wr_done_o.
